// File: rtl/mem_pkg.sv
// Shared definitions for the mem_ram_sync memory slice.
//   mem_state_e      : init/run state encoding
//   RDW_OLD/RDW_NEW  : read-during-write behaviour selectors
//   INIT_ZERO/INIT_INDEX : post-reset content pattern selectors
package mem_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } mem_state_e;

   localparam int RDW_OLD    = 0;
   localparam int RDW_NEW    = 1;
   localparam int INIT_ZERO  = 0;
   localparam int INIT_INDEX = 1;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-result pipeline of depth OUT_REG+1 with valid flag.
// Data registers only load alongside a valid beat, so the output word holds
// its last value while out_valid is low.
//   clk, rst_n           : clock, async active-low clear
//   in_valid, in_data    : stage-1 capture of an accepted read
//   out_valid, out_data  : read result after OUT_REG+1 edges
module mem_rd_pipe #(
   parameter int DATA_W  = 8,
   parameter int OUT_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic              s1_valid_d, s1_valid_q;
   logic [DATA_W-1:0] s1_data_d,  s1_data_q;

   always_comb begin
      s1_valid_d = in_valid;
      s1_data_d  = in_valid ? in_data : s1_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_s2
         logic              s2_valid_d, s2_valid_q;
         logic [DATA_W-1:0] s2_data_d,  s2_data_q;

         always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_valid_q <= 1'b0;
               s2_data_q  <= '0;
            end else begin
               s2_valid_q <= s2_valid_d;
               s2_data_q  <= s2_data_d;
            end
         end

         assign out_valid = s2_valid_q;
         assign out_data  = s2_data_q;
      end else begin : g_s1
         assign out_valid = s1_valid_q;
         assign out_data  = s1_data_q;
      end
   endgenerate

endmodule

// File: rtl/mem_ram_sync.sv
// Simple dual-port synchronous RAM: one write port, one read port, registered
// read with 1- or 2-cycle latency, post-reset content rebuild, range flagging.
//   mem_iclk, mem_irst_n         : clock, async active-low reset
//   iwr_en, iwr_addr, iwr_data   : write port
//   ird_en, ird_addr             : read port
//   odata, ovalid                : read result and its valid flag
//   obusy                        : init sweep in progress, requests ignored
//   oerr                         : one-cycle pulse after an out-of-range request
//
// state   | meaning
// ST_INIT | writing init pattern to address cnt, one word per cycle
// ST_RUN  | normal read/write service
module mem_ram_sync
   import mem_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 3,
   parameter int DEPTH     = 5,
   parameter int OUT_REG   = 1,
   parameter int RDW_MODE  = 0,
   parameter int INIT_MODE = 1
) (
   input  logic              mem_iclk,
   input  logic              mem_irst_n,
   input  logic              iwr_en,
   input  logic [ADDR_W-1:0] iwr_addr,
   input  logic [DATA_W-1:0] iwr_data,
   input  logic              ird_en,
   input  logic [ADDR_W-1:0] ird_addr,
   output logic [DATA_W-1:0] odata,
   output logic              ovalid,
   output logic              obusy,
   output logic              oerr
);

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];

   mem_state_e        state_d, state_q;
   logic [ADDR_W-1:0] cnt_d,   cnt_q;
   logic              err_d,   err_q;

   logic              run, wr_in, rd_in, wr_fire, rd_fire, we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata, rd_word;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      run     = (state_q == ST_RUN);
      wr_in   = ({1'b0, iwr_addr} < DEPTH_L);
      rd_in   = ({1'b0, ird_addr} < DEPTH_L);
      wr_fire = run & iwr_en & wr_in;
      rd_fire = run & ird_en & rd_in;
      // Both ports out of range in the same cycle still yield one pulse.
      err_d   = run & ((iwr_en & ~wr_in) | (ird_en & ~rd_in));
      we      = wr_fire;
      waddr   = iwr_addr;
      wdata   = iwr_data;
      if (!run) begin
         we    = 1'b1;
         waddr = cnt_q;
         wdata = (INIT_MODE == INIT_INDEX) ? DATA_W'(cnt_q) : '0;
         if (cnt_q == LAST_L) state_d = ST_RUN;
         else                 cnt_d   = cnt_q + ADDR_W'(1);
      end
      // Only consumed when rd_fire, so an out-of-range index is harmless here.
      rd_word = mem_q[ird_addr];
      if (RDW_MODE == RDW_NEW && wr_fire && iwr_addr == ird_addr) rd_word = iwr_data;
   end

   always_ff @(posedge mem_iclk or negedge mem_irst_n) begin
      if (!mem_irst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Array is deliberately not reset; the init sweep rebuilds it.
   always_ff @(posedge mem_iclk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   mem_rd_pipe #(
      .DATA_W  (DATA_W),
      .OUT_REG (OUT_REG)
   ) u_rd_pipe (
      .clk       (mem_iclk),
      .rst_n     (mem_irst_n),
      .in_valid  (rd_fire),
      .in_data   (rd_word),
      .out_valid (ovalid),
      .out_data  (odata)
   );

   assign obusy = (state_q == ST_INIT);
   assign oerr  = err_q;

endmodule

// File: tb/tb_mem_ram_sync.sv
module tb_mem_ram_sync;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: defaults (2-cycle latency, old data on collision)
   logic       a_wr_en = 0, a_rd_en = 0;
   logic [2:0] a_wr_addr = 0, a_rd_addr = 0;
   logic [7:0] a_wr_data = 0, a_odata;
   logic       a_ovalid, a_obusy, a_oerr;

   // Instance B: 1-cycle latency, new data on collision
   logic       b_wr_en = 0, b_rd_en = 0;
   logic [2:0] b_wr_addr = 0, b_rd_addr = 0;
   logic [7:0] b_wr_data = 0, b_odata;
   logic       b_ovalid, b_obusy, b_oerr;

   int n_checks = 0;
   int n_fail   = 0;

   mem_ram_sync u_a (
      .mem_iclk (clk), .mem_irst_n (rst_n),
      .iwr_en (a_wr_en), .iwr_addr (a_wr_addr), .iwr_data (a_wr_data),
      .ird_en (a_rd_en), .ird_addr (a_rd_addr),
      .odata (a_odata), .ovalid (a_ovalid), .obusy (a_obusy), .oerr (a_oerr)
   );

   mem_ram_sync #(.OUT_REG (0), .RDW_MODE (1)) u_b (
      .mem_iclk (clk), .mem_irst_n (rst_n),
      .iwr_en (b_wr_en), .iwr_addr (b_wr_addr), .iwr_data (b_wr_data),
      .ird_en (b_rd_en), .ird_addr (b_rd_addr),
      .odata (b_odata), .ovalid (b_ovalid), .obusy (b_obusy), .oerr (b_oerr)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   // Counts negedge samples with A busy; flags any ovalid/oerr while busy.
   task automatic a_busy_len(output int n, output int bad);
      n = 0;
      bad = 0;
      while (a_obusy && n < 20) begin
         if (a_ovalid || a_oerr) bad++;
         n++;
         @(negedge clk);
      end
   endtask

   // Single read on A, checked 2 cycles later.
   task automatic a_read(input logic [2:0] addr, input logic [7:0] exp, input string tag);
      a_rd_en = 1; a_rd_addr = addr;
      @(negedge clk);
      a_rd_en = 0;
      @(negedge clk);
      chk_eq({tag, "_v"}, a_ovalid, 1);
      chk_eq({tag, "_d"}, a_odata, exp);
   endtask

   initial begin
      int n, bad;
      logic [7:0] exp_sweep [5];
      exp_sweep = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};

      // ---- reset state
      repeat (2) @(negedge clk);
      chk_eq("rst_busy",  a_obusy, 1);
      chk_eq("rst_valid", a_ovalid, 0);
      chk_eq("rst_err",   a_oerr, 0);
      chk_eq("rst_data",  a_odata, 0);

      // ---- requests held during init (A), busy length
      a_rd_en = 1; a_rd_addr = 3'd1;
      a_wr_en = 1; a_wr_addr = 3'd1; a_wr_data = 8'hFF;
      rst_n = 1;
      a_busy_len(n, bad);
      a_rd_en = 0; a_wr_en = 0;
      chk_eq("init_busy_len", n, 5);
      chk_eq("init_no_resp", bad, 0);
      chk_eq("b_busy_done", b_obusy, 0);
      @(negedge clk);
      chk_eq("init_post_valid", a_ovalid, 0);

      // ---- back-to-back read sweep 0..4, latency 2
      for (int j = 0; j < 8; j++) begin
         chk_eq($sformatf("sweep_v%0d", j), a_ovalid, (j >= 2 && j <= 6) ? 1 : 0);
         if (j >= 2 && j <= 6) chk_eq($sformatf("sweep_d%0d", j), a_odata, exp_sweep[j-2]);
         a_rd_en = (j < 5); a_rd_addr = 3'(j);
         @(negedge clk);
      end
      a_rd_en = 0;

      // ---- write then read, B (latency 1)
      b_wr_en = 1; b_wr_addr = 3'd3; b_wr_data = 8'hA5;
      @(negedge clk);
      b_wr_en = 0; b_rd_en = 1; b_rd_addr = 3'd3;
      chk_eq("b_wr_novalid", b_ovalid, 0);
      @(negedge clk);
      b_rd_en = 0;
      chk_eq("b_rd_v", b_ovalid, 1);
      chk_eq("b_rd_d", b_odata, 8'hA5);
      @(negedge clk);
      chk_eq("b_hold_v", b_ovalid, 0);
      chk_eq("b_hold_d", b_odata, 8'hA5);

      // ---- collision on addr 2, A returns old data
      a_wr_en = 1; a_wr_addr = 3'd2; a_wr_data = 8'h5A;
      a_rd_en = 1; a_rd_addr = 3'd2;
      @(negedge clk);
      a_wr_en = 0; a_rd_en = 0;
      @(negedge clk);
      chk_eq("a_rdw_v", a_ovalid, 1);
      chk_eq("a_rdw_d", a_odata, 8'h02);
      a_read(3'd2, 8'h5A, "a_rdw_after");

      // ---- collision on addr 2, B returns new data
      b_wr_en = 1; b_wr_addr = 3'd2; b_wr_data = 8'h5A;
      b_rd_en = 1; b_rd_addr = 3'd2;
      @(negedge clk);
      b_wr_en = 0; b_rd_en = 0;
      chk_eq("b_rdw_v", b_ovalid, 1);
      chk_eq("b_rdw_d", b_odata, 8'h5A);

      // ---- out of range on both ports (A)
      a_rd_en = 1; a_rd_addr = 3'd6;
      a_wr_en = 1; a_wr_addr = 3'd7; a_wr_data = 8'h33;
      @(negedge clk);
      a_rd_en = 0; a_wr_en = 0;
      chk_eq("oor_err1", a_oerr, 1);
      chk_eq("oor_v1", a_ovalid, 0);
      @(negedge clk);
      chk_eq("oor_err2", a_oerr, 0);
      chk_eq("oor_v2", a_ovalid, 0);
      exp_sweep[2] = 8'h5A;
      for (int i = 0; i < 5; i++) a_read(3'(i), exp_sweep[i], $sformatf("oor_keep%0d", i));

      // ---- out of range write only (B), addr 5 is first illegal
      b_wr_en = 1; b_wr_addr = 3'd5; b_wr_data = 8'h11;
      @(negedge clk);
      b_wr_en = 0;
      chk_eq("b_oor_err", b_oerr, 1);
      chk_eq("b_oor_v", b_ovalid, 0);
      b_rd_en = 1; b_rd_addr = 3'd4;
      @(negedge clk);
      b_rd_en = 0;
      chk_eq("b_last_d", b_odata, 8'h04);
      chk_eq("b_err_clr", b_oerr, 0);

      // ---- reset mid-burst (A)
      a_wr_en = 1; a_wr_addr = 3'd4; a_wr_data = 8'h77;
      @(negedge clk);
      a_wr_en = 0;
      for (int k = 0; k < 4; k++) begin
         a_rd_en = 1; a_rd_addr = 3'(k);
         if (k == 3) begin
            chk_eq("burst_v", a_ovalid, 1);
            chk_eq("burst_d", a_odata, 8'h01);
         end
         if (k < 3) @(negedge clk);
      end
      #1 rst_n = 0;
      a_rd_en = 0;
      #1;
      chk_eq("mid_rst_v", a_ovalid, 0);
      chk_eq("mid_rst_busy", a_obusy, 1);
      @(negedge clk);
      rst_n = 1;
      a_busy_len(n, bad);
      chk_eq("reinit_busy_len", n, 5);
      chk_eq("reinit_no_resp", bad, 0);
      a_read(3'd4, 8'h04, "reinit_a4");
      a_read(3'd2, 8'h02, "reinit_a2");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_ram_sync.md
Name: mem_ram_sync

Overview:
Parametrised successor to the team's 5×8 registered-read memory. It is a simple dual-port synchronous RAM with one write port and one read port, each with its own address. Reads have a registered, selectable 1- or 2-cycle latency with a valid flag. An init state machine rebuilds the array contents after every reset, and out-of-range accesses are flagged. It sits between the datapath and any block needing small lookup or scratch storage.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 3, address width in bits
DEPTH, 5, number of words; legal range 2..2**ADDR_W
OUT_REG, 1, 0 = read latency 1 cycle; 1 = read latency 2 cycles (extra output register)
RDW_MODE, 0, read-during-write to same address: 0 = old data returned, 1 = new data returned (bypass)
INIT_MODE, 1, post-reset contents: 0 = all zeros; 1 = word i holds i, zero-extended/truncated to DATA_W

Ports:
mem_iclk  input  1  clock, all logic on rising edge
mem_irst_n  input  1  reset, asynchronous assert, active-low
iwr_en  input  1  write request
iwr_addr  input  ADDR_W  write address
iwr_data  input  DATA_W  write data
ird_en  input  1  read request
ird_addr  input  ADDR_W  read address
odata  output  DATA_W  read data, meaningful only when ovalid=1
ovalid  output  1  odata carries the result of a read issued OUT_REG+1 cycles earlier
obusy  output  1  init in progress; all requests are ignored while high
oerr  output  1  one-cycle pulse, one cycle after an out-of-range request (addr >= DEPTH) on either port

Behaviour:
- Fixed: one clock (mem_iclk). Reset mem_irst_n is asynchronous and active-low.
- While mem_irst_n=0: odata=0, ovalid=0, oerr=0, obusy=1, state=INIT, init counter=0, read pipeline flushed. Array contents are not reset directly.
- FSM has two states, INIT and RUN.
- INIT: each cycle writes the init pattern to address cnt, then cnt++.
  - On the cycle cnt==DEPTH-1, the last word is written and state goes to RUN.
  - obusy is high for exactly DEPTH cycles after reset release, then low.
- INIT: iwr_en and ird_en are ignored. No writes, no ovalid, no oerr.
- RUN, write: iwr_en=1 and iwr_addr<DEPTH writes iwr_data on that edge.
- RUN, read: ird_en=1 and ird_addr<DEPTH captures the array word on the same edge (stage 1).
  - OUT_REG=0: odata and ovalid appear after 1 edge.
  - OUT_REG=1: stage 2 adds one more edge, so latency is 2.
  - Fully pipelined: one read accepted per cycle; back-to-back reads give back-to-back ovalid.
- Out-of-range: iwr_en with iwr_addr>=DEPTH performs no write. ird_en with ird_addr>=DEPTH produces no ovalid.
  - Either case pulses oerr for 1 cycle after the request; both in the same cycle still give a single pulse.
- Read and write in the same cycle to different addresses: both proceed independently.
- Read and write in the same cycle to the same address:
  - RDW_MODE=0: the read returns the pre-write value.
  - RDW_MODE=1: the read returns iwr_data.
  - The array is updated in both modes.
- odata holds its last value when ovalid=0. It is not forced to zero after reset release.
- Reset asserted mid-operation: in-flight reads are dropped (ovalid=0 immediately), init restarts from address 0, and earlier contents are overwritten.
- Width rules: INIT_MODE=1 pattern is the counter zero-extended to DATA_W, truncated if DATA_W<ADDR_W. Counter width is ADDR_W; it never wraps past DEPTH-1.

Decomposition:
- Shared package mem_pkg: FSM state enum (ST_INIT, ST_RUN), RDW_OLD/RDW_NEW and INIT_ZERO/INIT_INDEX constants.
- One natural sub-module, mem_rd_pipe: the valid/data pipeline of depth OUT_REG+1, with async active-low clear.
- The array and FSM stay in mem_ram_sync.

Test Plan:
- Init sweep, defaults: release reset -> obusy=1 for 5 cycles, then 0; reads of addr 0..4 return 0,1,2,3,4 with ovalid exactly 2 cycles after each ird_en.
- Write then read, OUT_REG=0: write 8'hA5 to addr 3, next cycle read addr 3 -> odata=8'hA5 and ovalid=1 one cycle later.
- Same-address collision on addr 2 (holding 2), iwr_data=8'h5A: RDW_MODE=0 -> odata=8'h02 and a later read gives 8'h5A; RDW_MODE=1 -> odata=8'h5A.
- Out-of-range: ird_addr=6 and iwr_addr=7 in the same cycle -> oerr=1 for 1 cycle, no ovalid, addr 0..4 unchanged.
- Requests during init: ird_en and iwr_en (addr 1, 8'hFF) held high while obusy=1 -> no ovalid, no oerr; addr 1 reads 1 after init.
- Reset mid-burst: 4 back-to-back reads, assert mem_irst_n=0 after the 2nd -> ovalid drops immediately; on release, INIT repeats and earlier writes are restored to the init pattern.
